audio_tone_decoder: RTL and testbench

//  Receive-side counterpart of the square-wave sound generators: measures half-periods of a
//  1-bit audio line and reports which table note is playing, or silence. Sits on the speaker
//  net (or a loopback of it) for self-check of game jingles and for board-level audio monitoring.

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_edge_sync.sv | 25 ++
 rtl/audio_tone_decoder.sv | 149 ++++++++++++++
 tb/tb_audio_tone_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the square-wave tone generators and the tone decoder.
package audio_pkg;

   // Half-periods in clk cycles of the three table notes.
   localparam int NOTE_HALF [3] = '{114091, 128061, 143757};

   typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} tone_state_t;

   typedef logic [1:0] note_code_t;

endpackage

// File: rtl/audio_edge_sync.sv
// Brings the asynchronous audio line into clk and strobes one cycle on either edge.
module audio_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic audio_i,
   output logic edge_o
);

   logic [2:0] sync_q;
   logic       edge_q;

   // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous settled level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], audio_i};
         edge_q <= sync_q[1] ^ sync_q[2];
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/audio_tone_decoder.sv
// Measures half-periods of a 1-bit audio line and reports which table note is playing.
module audio_tone_decoder
   import audio_pkg::*;
#(
   parameter int CNT_W       = 19,
   parameter int TOL         = 2048,
   parameter int MATCH_N     = 4,
   parameter int SILENCE_CYC = 300000,
   parameter int NOTE0       = NOTE_HALF[0],
   parameter int NOTE1       = NOTE_HALF[1],
   parameter int NOTE2       = NOTE_HALF[2]
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             audio_in,
   output logic [1:0]       note_code,
   output logic             note_valid,
   output logic             locked,
   output logic [CNT_W-1:0] half_period
);

   localparam int                     MC_W   = $clog2(MATCH_N + 1);
   localparam logic [MC_W-1:0]        MN_V   = MC_W'(MATCH_N);
   localparam logic [CNT_W-1:0]       SIL_V  = CNT_W'(SILENCE_CYC);
   localparam logic signed [CNT_W:0]  TOL_S  = (CNT_W+1)'(TOL);
   localparam int                     NOTES [3] = '{NOTE0, NOTE1, NOTE2};

   logic rst_meta_q, rst_q;

   // Reset asserts immediately but is released two clocks later, in step with clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta_q <= 1'b1;
         rst_q      <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_q      <= rst_meta_q;
      end
   end

   logic edge_s;

   audio_edge_sync u_edge_sync (
      .clk     (clk),
      .reset   (rst_q),
      .audio_i (audio_in),
      .edge_o  (edge_s)
   );

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] meas;

   always_ff @(posedge clk or posedge rst_q) begin
      if (rst_q) begin
         cnt_q <= '0;
      end else if (edge_s) begin
         cnt_q <= '0;
      end else if (cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign meas = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   logic [2:0] hit;

   for (genvar gi = 0; gi < 3; gi++) begin : g_class
      logic signed [CNT_W:0] diff;
      assign diff    = $signed({1'b0, meas}) - $signed((CNT_W+1)'(NOTES[gi]));
      assign hit[gi] = (diff <= TOL_S) && (diff >= -TOL_S);
   end

   note_code_t cls;

   always_comb begin
      cls = 2'd0;
      if (hit[0])      cls = 2'd1;
      else if (hit[1]) cls = 2'd2;
      else if (hit[2]) cls = 2'd3;
   end

   tone_state_t      state_q, state_d;
   note_code_t       cand_q, cand_d;
   logic [MC_W-1:0]  mc_q, mc_d;
   note_code_t       code_q, code_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] half_q, half_d;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      mc_d    = mc_q;
      code_d  = code_q;
      half_d  = half_q;
      valid_d = 1'b0;
      if (edge_s) begin
         if (state_q == SILENT) begin
            // First edge only establishes the reference point.
            state_d = ACQUIRE;
            cand_d  = 2'd0;
            mc_d    = '0;
         end else begin
            half_d = meas;
            if (!(state_q == LOCKED && cls == code_q)) begin
               if (state_q == ACQUIRE && cls == cand_q && cls != 2'd0) begin
                  mc_d = mc_q + MC_W'(1);
               end else begin
                  cand_d = cls;
                  mc_d   = (cls != 2'd0) ? MC_W'(1) : '0;
               end
               state_d = ACQUIRE;
               if (mc_d >= MN_V) begin
                  state_d = LOCKED;
                  code_d  = cand_d;
                  valid_d = (cand_d != code_q);
               end
            end
         end
      end else if (cnt_q >= SIL_V && state_q != SILENT) begin
         state_d = SILENT;
         code_d  = 2'd0;
         valid_d = (code_q != 2'd0);
      end
   end

   always_ff @(posedge clk or posedge rst_q) begin
      if (rst_q) begin
         state_q <= SILENT;
         cand_q  <= 2'd0;
         mc_q    <= '0;
         code_q  <= 2'd0;
         valid_q <= 1'b0;
         half_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         mc_q    <= mc_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         half_q  <= half_d;
      end
   end

   assign note_code   = code_q;
   assign note_valid  = valid_q;
   assign locked      = (state_q == LOCKED);
   assign half_period = half_q;

endmodule

// File: tb/tb_audio_tone_decoder.sv
// Bench for audio_tone_decoder using a scaled note table so runs stay short.
module tb_audio_tone_decoder;

   localparam int CW   = 9;
   localparam int CMAX = 511;
   localparam int TOLV = 5;
   localparam int MN   = 4;
   localparam int SIL  = 300;
   localparam int NOTES [3] = '{60, 80, 100};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          audio_in = 1'b0;
   logic [1:0]    note_code;
   logic          note_valid;
   logic          locked;
   logic [CW-1:0] half_period;

   int total = 0;
   int bad = 0;
   int pulses = 0;

   audio_tone_decoder #(
      .CNT_W(CW), .TOL(TOLV), .MATCH_N(MN), .SILENCE_CYC(SIL),
      .NOTE0(60), .NOTE1(80), .NOTE2(100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .audio_in    (audio_in),
      .note_code   (note_code),
      .note_valid  (note_valid),
      .locked      (locked),
      .half_period (half_period)
   );

   always #5 clk = ~clk;

   // Reference model: state 0 silent, 1 acquiring, 2 locked.
   int       m_state = 0, m_cand = 0, m_mc = 0, m_code = 0, m_valid = 0, m_half = 0;
   int       last = 0, pcnt = 0, hold = 0;
   bit [4:0] samp = '0;

   function automatic int classify(input int meas);
      for (int k = 0; k < 3; k++) begin
         int d;
         d = meas - NOTES[k];
         if (d < 0) d = -d;
         if (d <= TOLV) return k + 1;
      end
      return 0;
   endfunction

   initial begin : model
      forever begin
         @(posedge clk or posedge reset);
         if (reset || hold > 0) begin
            if (reset) hold = 2;
            else hold--;
            samp = '0; m_state = 0; m_cand = 0; m_mc = 0;
            m_code = 0; m_valid = 0; m_half = 0;
         end else begin
            pcnt++;
            samp = {samp[3:0], audio_in};
            m_valid = 0;
            // An input edge is acted on three clocks after it is first sampled.
            if (samp[3] != samp[4]) begin
               if (m_state == 0) begin
                  m_state = 1; m_cand = 0; m_mc = 0;
               end else begin
                  int meas, c;
                  meas = pcnt - last;
                  if (meas > CMAX) meas = CMAX;
                  m_half = meas;
                  c = classify(meas);
                  if (m_state == 2 && c == m_code) begin
                     m_state = 2;
                  end else if (m_state == 1 && c == m_cand && c != 0) begin
                     m_mc++;
                  end else begin
                     m_cand = c; m_mc = (c != 0) ? 1 : 0; m_state = 1;
                  end
                  if (m_state == 1 && m_mc >= MN) begin
                     m_state = 2;
                     if (m_cand != m_code) m_valid = 1;
                     m_code = m_cand;
                  end
               end
               last = pcnt;
            end else if (m_state != 0 && pcnt - 1 - last >= SIL) begin
               m_state = 0;
               if (m_code != 0) m_valid = 1;
               m_code = 0;
            end
         end
      end
   end

   initial begin : scoreboard
      forever begin
         logic [CW+3:0] exp_v, got_v;
         @(negedge clk);
         exp_v = {2'(m_code), (m_state == 2), 1'(m_valid), CW'(m_half)};
         got_v = {note_code, locked, note_valid, half_period};
         total++;
         if (got_v !== exp_v) begin
            bad++;
            $display("FAIL scoreboard t=%0t got code=%0d locked=%0d valid=%0d half=%0d expected code=%0d locked=%0d valid=%0d half=%0d",
                     $time, note_code, locked, note_valid, half_period,
                     m_code, m_state == 2, m_valid, m_half);
         end
         if (note_valid === 1'b1) pulses++;
      end
   end

   task automatic half(input int n);
      audio_in = ~audio_in;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int p0;
      reset = 1'b1;
      repeat (6) begin
         audio_in = ~audio_in;
         @(posedge clk); #1;
      end
      total++;
      if (note_code !== 2'd0 || locked !== 1'b0 || note_valid !== 1'b0 || half_period !== '0) begin
         bad++;
         $display("FAIL reset_hold got code=%0d locked=%0d valid=%0d half=%0d expected all 0",
                  note_code, locked, note_valid, half_period);
      end
      audio_in = 1'b0;
      reset = 1'b0;
      p0 = pulses;
      repeat (1000) @(posedge clk);
      #1;
      total++;
      if (note_code !== 2'd0 || locked !== 1'b0 || half_period !== '0 || pulses != p0) begin
         bad++;
         $display("FAIL reset_static got code=%0d locked=%0d half=%0d pulses=%0d expected 0 0 0 %0d",
                  note_code, locked, half_period, pulses, p0);
      end
      $display("test_reset: code=%0d locked=%0d", note_code, locked);
   endtask

   task automatic test_lock();
      int p0;
      p0 = pulses;
      repeat (5) half(60);
      total++;
      if (note_code !== 2'd1 || locked !== 1'b1 || half_period !== CW'(60) || pulses != p0 + 1) begin
         bad++;
         $display("FAIL lock got code=%0d locked=%0d half=%0d pulses=%0d expected 1 1 60 %0d",
                  note_code, locked, half_period, pulses - p0, 1);
      end
      repeat (3) half(60);
      total++;
      if (locked !== 1'b1 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL lock_hold got locked=%0d pulses=%0d expected 1 1", locked, pulses - p0);
      end
      $display("test_lock: code=%0d locked=%0d half=%0d", note_code, locked, half_period);
   endtask

   task automatic test_change();
      int p0;
      p0 = pulses;
      half(80);
      half(80);
      total++;
      if (note_code !== 2'd1 || locked !== 1'b0 || half_period !== CW'(80) || pulses != p0) begin
         bad++;
         $display("FAIL change_drop got code=%0d locked=%0d half=%0d pulses=%0d expected 1 0 80 0",
                  note_code, locked, half_period, pulses - p0);
      end
      repeat (3) half(80);
      total++;
      if (note_code !== 2'd2 || locked !== 1'b1 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL change_lock got code=%0d locked=%0d pulses=%0d expected 2 1 1",
                  note_code, locked, pulses - p0);
      end
      $display("test_change: code=%0d locked=%0d", note_code, locked);
   endtask

   task automatic test_silence();
      int p0;
      p0 = pulses;
      repeat (SIL - 90) @(posedge clk);
      #1;
      total++;
      if (note_code !== 2'd2 || locked !== 1'b1) begin
         bad++;
         $display("FAIL silence_early got code=%0d locked=%0d expected 2 1", note_code, locked);
      end
      repeat (30) @(posedge clk);
      #1;
      total++;
      if (note_code !== 2'd0 || locked !== 1'b0 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL silence got code=%0d locked=%0d pulses=%0d expected 0 0 1",
                  note_code, locked, pulses - p0);
      end
      $display("test_silence: code=%0d locked=%0d", note_code, locked);
   endtask

   task automatic test_tolerance();
      int p0, p1;
      p0 = pulses;
      repeat (6) half(60 + TOLV);
      total++;
      if (note_code !== 2'd1 || locked !== 1'b1 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL tol_edge got code=%0d locked=%0d pulses=%0d expected 1 1 1",
                  note_code, locked, pulses - p0);
      end
      repeat (SIL + 20) @(posedge clk);
      #1;
      p1 = pulses;
      repeat (8) half(60 + TOLV + 1);
      repeat (8) half(50);
      total++;
      if (note_code !== 2'd0 || locked !== 1'b0 || pulses != p1) begin
         bad++;
         $display("FAIL off_table got code=%0d locked=%0d pulses=%0d expected 0 0 0",
                  note_code, locked, pulses - p1);
      end
      repeat (SIL + 20) @(posedge clk);
      #1;
      // Gap of SIL+1 is measured (edge beats timeout); SIL+2 times out first.
      half(10); half(SIL + 1); half(10);
      total++;
      if (half_period !== CW'(SIL + 1) || locked !== 1'b0) begin
         bad++;
         $display("FAIL edge_wins got half=%0d locked=%0d expected %0d 0", half_period, locked, SIL + 1);
      end
      half(SIL + 2); half(10);
      total++;
      if (half_period !== CW'(10)) begin
         bad++;
         $display("FAIL timeout_first got half=%0d expected 10", half_period);
      end
      repeat (SIL + 20) @(posedge clk);
      #1;
      $display("test_tolerance: code=%0d locked=%0d", note_code, locked);
   endtask

   task automatic test_glitch_reset();
      int p0;
      p0 = pulses;
      repeat (6) half(60);
      half(5);
      half(60);
      total++;
      if (note_code !== 2'd1 || locked !== 1'b0) begin
         bad++;
         $display("FAIL glitch_drop got code=%0d locked=%0d expected 1 0", note_code, locked);
      end
      repeat (4) half(60);
      total++;
      if (note_code !== 2'd1 || locked !== 1'b1 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL glitch_relock got code=%0d locked=%0d pulses=%0d expected 1 1 1",
                  note_code, locked, pulses - p0);
      end
      reset = 1'b1;
      #1;
      total++;
      if (note_code !== 2'd0 || locked !== 1'b0 || half_period !== '0) begin
         bad++;
         $display("FAIL mid_reset got code=%0d locked=%0d half=%0d expected 0 0 0",
                  note_code, locked, half_period);
      end
      audio_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      p0 = pulses;
      repeat (4) half(60);
      total++;
      if (locked !== 1'b0 || note_code !== 2'd0) begin
         bad++;
         $display("FAIL relock_early got code=%0d locked=%0d expected 0 0", note_code, locked);
      end
      half(60);
      total++;
      if (locked !== 1'b1 || note_code !== 2'd1 || pulses != p0 + 1) begin
         bad++;
         $display("FAIL relock got code=%0d locked=%0d pulses=%0d expected 1 1 1",
                  note_code, locked, pulses - p0);
      end
      $display("test_glitch_reset: code=%0d locked=%0d", note_code, locked);
   endtask

   task automatic test_random();
      int e0;
      e0 = bad;
      for (int i = 0; i < 120; i++) begin
         int r, k, n, reps;
         r = $urandom_range(0, 9);
         k = $urandom_range(0, 2);
         reps = 1;
         if (r < 6) begin
            n = NOTES[k] + $urandom_range(0, 14) - 7;
            reps = $urandom_range(1, 6);
         end else if (r == 6) begin
            n = NOTES[k] + (($urandom_range(0, 1) == 1) ? TOLV : -TOLV) + $urandom_range(0, 1);
            reps = $urandom_range(1, 5);
         end else if (r == 7) begin
            n = $urandom_range(2, 40);
         end else if (r == 8) begin
            n = $urandom_range(SIL - 5, SIL + 10);
         end else begin
            n = NOTES[k];
            reps = $urandom_range(4, 7);
         end
         repeat (reps) half(n);
         $display("rand %0d: half=%0d x%0d code=%0d locked=%0d", i, n, reps, note_code, locked);
      end
      total++;
      if (bad != e0) begin
         $display("FAIL random got %0d scoreboard errors expected 0", bad - e0);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_lock();
      test_change();
      test_silence();
      test_tolerance();
      test_glitch_reset();
      test_random();
      repeat (10) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
